// File: rtl/core_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: state encoding, counter width
// default and the fetch-stage control bundle.
package core_fetch_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ADDR_W    = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic ic_req;
    logic enb;
    logic kill;
    logic pc_stop;
    logic sel;
  } fetch_ctl_t;

endpackage

// File: rtl/core_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module core_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/core_fetch_ctrl.sv
// Instruction fetch controller: sequences L1 I-cache requests, decode stalls
// and execute redirects, and keeps stall/redirect performance counters.
module core_fetch_ctrl
  import core_fetch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_ack,
  input  logic              dec_stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              ic_req,
  output logic              if_enb,
  output logic              if_kill,
  output logic              if_pc_stop,
  output logic              if_mux1_trn_pc_4_s,
  output logic [ADDR_W-1:0] if_mux1_addr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redir_cnt
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] redir_addr, redir_nxt;
  logic [ADDR_W-1:0] mux_addr;
  fetch_ctl_t        ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      redir_addr <= '0;
    end else begin
      state      <= state_nxt;
      redir_addr <= redir_nxt;
    end
  end

  // Next state and Moore/Mealy control; redirects always kill the F/D register.
  always_comb begin
    state_nxt   = state;
    redir_nxt   = redir_addr;
    mux_addr    = redir_addr;
    ctl         = '0;
    ctl.pc_stop = 1'b1;
    case (state)
      ST_BOOT: begin
        ctl.kill  = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        ctl.ic_req = 1'b1;
        if (br_taken) begin
          ctl.kill = 1'b1;
          if (ic_ack) begin
            ctl.sel     = 1'b1;
            ctl.pc_stop = 1'b0;
            mux_addr    = br_addr;
          end else begin
            redir_nxt = br_addr;
            state_nxt = ST_DRAIN;
          end
        end else if (ic_ack) begin
          if (!dec_stall) begin
            ctl.enb     = 1'b1;
            ctl.pc_stop = 1'b0;
          end else begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          ctl.sel     = 1'b1;
          ctl.kill    = 1'b1;
          ctl.pc_stop = 1'b0;
          mux_addr    = br_addr;
          state_nxt   = ST_FETCH;
        end else if (!dec_stall) begin
          ctl.enb     = 1'b1;
          ctl.pc_stop = 1'b0;
          state_nxt   = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // Stale request still in flight: its data is discarded, never loaded.
        ctl.ic_req = 1'b1;
        ctl.kill   = 1'b1;
        if (br_taken) begin
          redir_nxt = br_addr;
        end
        if (ic_ack) begin
          ctl.sel     = 1'b1;
          ctl.pc_stop = 1'b0;
          mux_addr    = br_taken ? br_addr : redir_addr;
          state_nxt   = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  assign ic_req             = ctl.ic_req;
  assign if_enb             = ctl.enb;
  assign if_kill            = ctl.kill;
  assign if_pc_stop         = ctl.pc_stop;
  assign if_mux1_trn_pc_4_s = ctl.sel;
  assign if_mux1_addr       = mux_addr;

  core_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctl.pc_stop),
    .count (stall_cnt)
  );

  core_sat_cnt #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctl.sel & ~ctl.pc_stop),
    .count (redir_cnt)
  );

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Scoreboard bench for core_fetch_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_core_fetch_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_ack = 1'b0;
  logic          dec_stall = 1'b0;
  logic          br_taken = 1'b0;
  logic [31:0]   br_addr = '0;
  logic          ic_req, if_enb, if_kill, if_pc_stop, if_mux1_trn_pc_4_s;
  logic [31:0]   if_mux1_addr;
  logic [CW-1:0] stall_cnt, redir_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [4:0]  ctl;      // {ic_req, enb, kill, pc_stop, sel}
    bit          chk_addr;
    logic [31:0] addr;
    logic [3:0]  sc;
    logic [3:0]  rc;
  } exp_t;

  exp_t exp_q[$];

  core_fetch_ctrl #(.CNT_W(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ic_ack             (ic_ack),
    .dec_stall          (dec_stall),
    .br_taken           (br_taken),
    .br_addr            (br_addr),
    .ic_req             (ic_req),
    .if_enb             (if_enb),
    .if_kill            (if_kill),
    .if_pc_stop         (if_pc_stop),
    .if_mux1_trn_pc_4_s (if_mux1_trn_pc_4_s),
    .if_mux1_addr       (if_mux1_addr),
    .stall_cnt          (stall_cnt),
    .redir_cnt          (redir_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] got;
      e = exp_q.pop_front();
      got = {ic_req, if_enb, if_kill, if_pc_stop, if_mux1_trn_pc_4_s};
      tests++;
      if (got !== e.ctl) begin
        fails++;
        $display("FAIL %s ctl {req,enb,kill,stop,sel}: got %b want %b", e.name, got, e.ctl);
      end
      if (e.chk_addr) begin
        tests++;
        if (if_mux1_addr !== e.addr) begin
          fails++;
          $display("FAIL %s addr: got %h want %h", e.name, if_mux1_addr, e.addr);
        end
      end
      tests++;
      if (stall_cnt !== e.sc) begin
        fails++;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.sc);
      end
      tests++;
      if (redir_cnt !== e.rc) begin
        fails++;
        $display("FAIL %s redir_cnt: got %0d want %0d", e.name, redir_cnt, e.rc);
      end
    end
  end

  task automatic push(input string nm, input logic [4:0] ctl, input bit ca,
                      input logic [31:0] addr, input logic [3:0] sc, input logic [3:0] rc);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.chk_addr = ca; e.addr = addr; e.sc = sc; e.rc = rc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    rst_n = 1'b0; ic_ack = 1'b0; dec_stall = 1'b0; br_taken = 1'b0; br_addr = '0;
    push(nm, 5'b00110, 1'b1, 32'h0, 4'd0, 4'd0);
  endtask

  // One cycle of stimulus plus its expectation; mid_rst pulls reset inside the cycle.
  task automatic step(input logic ack, input logic ds, input logic bt, input logic [31:0] ba,
                      input string nm, input logic [4:0] ctl, input bit ca, input logic [31:0] addr,
                      input logic [3:0] sc, input logic [3:0] rc, input bit mid_rst = 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; ic_ack = ack; dec_stall = ds; br_taken = bt; br_addr = ba;
    push(nm, ctl, ca, addr, sc, rc);
    if (mid_rst) begin
      #2 rst_n = 1'b0;
    end
  endtask

  localparam logic [4:0] C_BOOT  = 5'b00110;
  localparam logic [4:0] C_LOAD  = 5'b11000;
  localparam logic [4:0] C_WAIT  = 5'b10010;
  localparam logic [4:0] C_KILLW = 5'b10110;
  localparam logic [4:0] C_REDIR = 5'b10101;

  initial begin
    // Boot with ack tied high, then streaming fetches
    do_reset("rst0");
    step(1, 0, 0, 0, "boot", C_BOOT, 1'b0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, "stream", C_LOAD, 1'b0, 0, 1, 0);
    // Three missing acks then a load
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, "miss", C_WAIT, 1'b0, 0, 4'(i), 0);
    step(1, 0, 0, 0, "miss_done", C_LOAD, 1'b0, 0, 4, 0);
    step(1, 0, 0, 0, "miss_after", C_LOAD, 1'b0, 0, 4, 0);

    // Redirect with no ack -> DRAIN, then ack two cycles later
    do_reset("rst1");
    step(0, 0, 0, 0, "boot1", C_BOOT, 1'b0, 0, 0, 0);
    step(0, 0, 1, 32'h100, "br_noack", C_KILLW, 1'b0, 0, 1, 0);
    step(0, 0, 0, 0, "drain_a", C_KILLW, 1'b1, 32'h100, 2, 0);
    step(0, 0, 0, 0, "drain_b", C_KILLW, 1'b1, 32'h100, 3, 0);
    step(1, 0, 0, 0, "drain_ack", C_REDIR, 1'b1, 32'h100, 4, 0);
    step(1, 0, 0, 0, "post_drain", C_LOAD, 1'b0, 0, 4, 1);
    // Second redirect inside DRAIN overrides the first target
    step(0, 0, 1, 32'h180, "br2", C_KILLW, 1'b0, 0, 4, 1);
    step(0, 0, 1, 32'h200, "drain_br", C_KILLW, 1'b1, 32'h180, 5, 1);
    step(1, 0, 0, 0, "drain_ack2", C_REDIR, 1'b1, 32'h200, 6, 1);
    step(0, 0, 1, 32'h250, "br3", C_KILLW, 1'b0, 0, 6, 2);
    step(1, 0, 1, 32'h300, "drain_br_ack", C_REDIR, 1'b1, 32'h300, 7, 2);
    step(1, 0, 0, 0, "post3", C_LOAD, 1'b0, 0, 7, 3);
    // Redirect with ack in FETCH; branch beats dec_stall
    step(1, 1, 1, 32'h400, "fetch_br_ack", C_REDIR, 1'b1, 32'h400, 7, 3);
    step(1, 0, 0, 0, "post4", C_LOAD, 1'b0, 0, 7, 4);

    // Decode stall -> HOLD, branch in HOLD
    do_reset("rst2");
    step(1, 1, 0, 0, "boot2", C_BOOT, 1'b0, 0, 0, 0);
    step(1, 1, 0, 0, "ack_stall", C_WAIT, 1'b0, 0, 1, 0);
    step(0, 1, 0, 0, "hold_a", 5'b00010, 1'b0, 0, 2, 0);
    step(0, 1, 0, 0, "hold_b", 5'b00010, 1'b0, 0, 3, 0);
    step(0, 1, 1, 32'h500, "hold_br", 5'b00101, 1'b1, 32'h500, 4, 0);
    step(0, 0, 0, 0, "after_hold_br", C_WAIT, 1'b0, 0, 4, 1);
    step(1, 1, 0, 0, "ack_stall2", C_WAIT, 1'b0, 0, 5, 1);
    step(0, 0, 0, 0, "hold_release", 5'b01000, 1'b0, 0, 6, 1);
    step(0, 0, 0, 0, "after_release", C_WAIT, 1'b0, 0, 6, 1);

    // Stall counter saturation, then async reset mid-DRAIN
    do_reset("rst3");
    step(0, 0, 0, 0, "boot3", C_BOOT, 1'b0, 0, 0, 0);
    for (int i = 1; i <= 20; i++)
      step(0, 0, 0, 0, "sat", C_WAIT, 1'b0, 0, (i > 15) ? 4'd15 : 4'(i), 0);
    step(0, 0, 1, 32'h600, "br_sat", C_KILLW, 1'b0, 0, 15, 0);
    step(0, 0, 0, 0, "async_rst", C_BOOT, 1'b1, 32'h0, 0, 0, 1'b1);
    step(1, 0, 0, 0, "boot_after_rst", C_BOOT, 1'b1, 32'h0, 0, 0);
    step(1, 0, 0, 0, "fetch_after_rst", C_LOAD, 1'b0, 0, 1, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
